// File: rtl/hmc_mem_pkg.sv
// rtl/hmc_mem_pkg.sv - shared types, memory-map bounds and address decode for mem_responder
package hmc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_VEC_LO = 2'd1,
    REG_VEC_HI = 2'd2,
    REG_NONE   = 2'd3
  } region_t;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_TOP  = 16'h03FF;
  localparam logic [15:0] VEC_LO   = 16'hFFFC;
  localparam logic [15:0] VEC_HI   = 16'hFFFD;
  localparam logic [7:0]  OPEN_BUS = 8'hFF;

  // Offset compare keeps the RAM window check valid for any base without
  // relying on an always-true lower bound when the base is zero.
  function automatic region_t decode(input logic [15:0] a);
    logic [15:0] off;
    off = a - RAM_BASE;
    if (off <= (RAM_TOP - RAM_BASE)) return REG_RAM;
    if (a == VEC_LO)                 return REG_VEC_LO;
    if (a == VEC_HI)                 return REG_VEC_HI;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU access bus between initiator and mem_responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        bus_err;

  modport master (output req, we, addr, wdata, input rdata, ready, bus_err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, bus_err);
endinterface

// File: rtl/mem_ram.sv
// rtl/mem_ram.sv - 1024x8 RAM, synchronous write, combinational read
module mem_ram (
  input  logic       ph1,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [0:1023];

  // Storage is deliberately not reset so contents survive a responder reset.
  always_ff @(posedge ph1) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with RAM, reset vector and bus error
module mem_responder
  import hmc_mem_pkg::*;
#(
  parameter int          WAIT_STATES  = 2,
  parameter logic [15:0] RESET_VECTOR = 16'h0200
) (
  input  logic            ph1,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  ram_rd_data;
  logic        ram_wr_en;

  // Sequencing: latch the request in IDLE, count wait states, respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response is computed from the access about to enter RESP so the outputs can be registered.
  always_comb begin
    ready_d   = 1'b0;
    rdata_d   = 8'h00;
    bus_err_d = 1'b0;
    if (state_d == RESP) begin
      ready_d = 1'b1;
      unique case (decode(addr_d))
        REG_RAM:    rdata_d = we_d ? 8'h00 : ram_rd_data;
        REG_VEC_LO: rdata_d = we_d ? 8'h00 : RESET_VECTOR[7:0];
        REG_VEC_HI: rdata_d = we_d ? 8'h00 : RESET_VECTOR[15:8];
        default: begin
          rdata_d   = we_d ? 8'h00 : OPEN_BUS;
          bus_err_d = 1'b1;
        end
      endcase
    end
  end

  // Write lands on the edge closing RESP; reset forces IDLE so a dropped write never commits.
  assign ram_wr_en = (state_q == RESP) && we_q && (decode(addr_q) == REG_RAM);

  mem_ram u_ram (
    .ph1     (ph1),
    .wr_en   (ram_wr_en),
    .wr_addr (addr_q[9:0]),
    .wr_data (wdata_q),
    .rd_addr (addr_d[9:0]),
    .rd_data (ram_rd_data)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      ready_q   <= 1'b0;
      rdata_q   <= 8'h00;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rdata   = rdata_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of wait cycles inserted before each response (legal 0..15).
REQ-002 Parameter RESET_VECTOR, default 16'h0200, value returned for reads of 16'hFFFC (low byte) and 16'hFFFD (high byte).
REQ-003 Port ph1  input  1  the only clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  1  CPU access request; held high by the initiator until ready is seen.
REQ-006 Port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 Port addr  input  16  CPU byte address; sampled with req.
REQ-008 Port wdata  input  8  write data; sampled with req.
REQ-009 Port rdata  output  8  read data; valid only while ready=1.
REQ-010 Port ready  output  1  one-cycle completion pulse for the latched access.
REQ-011 Port bus_err  output  1  one-cycle pulse, coincident with ready, for an access to an unmapped address.

Function
REQ-012 The memory map SHALL be: RAM 16'h0000-16'h03FF (1 KiB, read/write); vector bytes 16'hFFFC/16'hFFFD (read-only); all other addresses unmapped.
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, addr/we/wdata SHALL be latched; next state WAIT with counter = WAIT_STATES-1, or RESP if WAIT_STATES=0.
REQ-015 In WAIT, the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge where counter = 0.
REQ-016 Latency: req sampled in IDLE at cycle N -> ready=1 in cycle N+1+WAIT_STATES, for exactly one cycle.
REQ-017 In RESP, ready=1 and next state SHALL be IDLE unconditionally; req is ignored in RESP and WAIT.
REQ-018 Deassertion of req during WAIT SHALL NOT abort the access; it completes with the latched values.
REQ-019 RAM write SHALL commit on the clock edge ending the RESP cycle; a read in the following access to the same address returns the new byte.
REQ-020 Reads: RAM -> stored byte; 16'hFFFC -> RESET_VECTOR[7:0]; 16'hFFFD -> RESET_VECTOR[15:8]; unmapped -> 8'hFF with bus_err=1.
REQ-021 Writes to vector bytes SHALL be ignored with bus_err=0; writes to unmapped addresses SHALL be ignored with bus_err=1.
REQ-022 RAM addressing SHALL use addr[9:0] only after the region check; no aliasing of RAM above 16'h03FF.
REQ-023 When ready=0, rdata SHALL be 8'h00 and bus_err SHALL be 0.

Reset
REQ-024 Reset SHALL force state IDLE, counter 0, ready=0, bus_err=0, rdata=8'h00, latched request cleared, regardless of current state.
REQ-025 Reset mid-access SHALL drop the access; a pending write SHALL NOT commit; RAM contents are not cleared.
REQ-026 The first request SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-027 Package hmc_mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), region bounds (RAM_BASE, RAM_TOP, VEC_LO, VEC_HI) and OPEN_BUS = 8'hFF.
REQ-028 One sub-module, mem_ram (1024x8, synchronous write, combinational read, ph1 clock), SHALL hold RAM storage; decode, FSM and counter stay in mem_responder.

Verification
REQ-029 WAIT_STATES=2: reset, then read 16'hFFFC at cycle N -> ready at N+3, rdata=8'h00; read 16'hFFFD -> rdata=8'h02.
REQ-030 Write 8'hA5 to 16'h0010, then read 16'h0010 -> rdata=8'hA5, bus_err=0; read 16'h0410 -> rdata=8'hFF, bus_err=1.
REQ-031 WAIT_STATES=0: read 16'h0000 at cycle N -> ready at N+1; back-to-back reqs complete every second cycle.
REQ-032 req dropped one cycle after acceptance (WAIT_STATES=3) -> ready still pulses at N+4 with latched address data.
REQ-033 Write 8'h3C to 16'h0020 with reset asserted during WAIT -> ready never pulses; later read of 16'h0020 returns the prior value, not 8'h3C.
REQ-034 Write 8'h77 to 16'hFFFC -> ready pulses, bus_err=0; subsequent read of 16'hFFFC still returns 8'h00.
